// File: rtl/machine_d_pkg.sv
// Shared definitions for machine_d and its downstream consumers.
//   S_W     : width of the machine_d state code
//   A_W     : width of the machine_d data word
//   ENTRY_W : width of one captured snapshot {tag, S, A}
//   TAG_F   : tag for an F rising-edge event
//   TAG_S   : tag for an S change event
//   mk_entry: packs a snapshot into the capture entry layout
package machine_d_pkg;

  localparam int S_W     = 3;
  localparam int A_W     = 12;
  localparam int ENTRY_W = 1 + S_W + A_W;

  localparam logic TAG_F = 1'b0;
  localparam logic TAG_S = 1'b1;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t mk_entry(input logic tag,
                                      input logic [S_W-1:0] s,
                                      input logic [A_W-1:0] a);
    return {tag, s, a};
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// First-word-fall-through FIFO holding machine_d capture entries.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : write request (i_wdata)
//   i_pop        : read request; ignored while empty
//   o_rdata      : head entry, zero while empty
//   o_empty/o_full/o_count : registered occupancy
//   o_push_ok    : the current push request will be stored this edge
// A push into a full FIFO is accepted only when a pop frees a slot on the
// same edge; otherwise it is refused and the contents are left untouched.
module capture_fifo
  import machine_d_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  entry_t        i_wdata,
  output entry_t        o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_push_ok
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;
  entry_t        r_mem [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_count_nxt;

  assign w_pop       = i_pop && !r_empty;
  assign w_push      = i_push && (!r_full || w_pop);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata   = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_count   = r_count;
  assign o_push_ok = w_push;

endmodule

// File: rtl/machine_d_capture.sv
// Downstream consumer of machine_d: detects F rising edges and buffers a
// {tag, S, A} snapshot per event in a FWFT FIFO drained by the host.
// Optional feature macro: TRANSITION_LOG_EN -- also log S changes (tag 1);
// an F event in the same cycle takes priority and the S change is discarded.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   F, S, A    : machine_d flag, state code, data word
//   rd_en      : pop request
//   rd_data    : head entry (zero while empty)
//   empty, full, count : FIFO occupancy
//   evt_cnt    : events since reset (accepted or dropped), wraps
//   ovf        : sticky dropped-event flag
//   ovf_cnt    : dropped events, saturating
module machine_d_capture
  import machine_d_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int OVF_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               F,
  input  logic [S_W-1:0]     S,
  input  logic [A_W-1:0]     A,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        count,
  output logic [15:0]        evt_cnt,
  output logic               ovf,
  output logic [OVF_W-1:0]   ovf_cnt
);

  logic             r_f_prev;
  logic [15:0]      r_evt_cnt;
  logic             r_ovf;
  logic [OVF_W-1:0] r_ovf_cnt;

  logic             w_f_evt;
  logic             w_s_evt;
  logic             w_push;
  logic             w_push_ok;
  logic             w_drop;
  entry_t           w_wdata;

  assign w_f_evt = F && !r_f_prev;

`ifdef TRANSITION_LOG_EN
  logic [S_W-1:0] r_s_prev;

  // S change only produces an entry when no F event claims this cycle.
  assign w_s_evt = (S != r_s_prev) && !w_f_evt;

  always_ff @(posedge CLK) begin
    if (RESET) r_s_prev <= '0;
    else       r_s_prev <= S;
  end
`else
  assign w_s_evt = 1'b0;
`endif

  assign w_push  = w_f_evt || w_s_evt;
  assign w_wdata = mk_entry(w_f_evt ? TAG_F : TAG_S, S, A);
  assign w_drop  = w_push && !w_push_ok;

  capture_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_push    (w_push),
    .i_pop     (rd_en),
    .i_wdata   (w_wdata),
    .o_rdata   (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count),
    .o_push_ok (w_push_ok)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_f_prev  <= 1'b0;
      r_evt_cnt <= '0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_f_prev <= F;
      if (w_push) r_evt_cnt <= r_evt_cnt + 16'd1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
    end
  end

  assign evt_cnt = r_evt_cnt;
  assign ovf     = r_ovf;
  assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_machine_d_capture.sv
// Bench for machine_d_capture: table of vectors for the basic capture
// sequences, plus hand-written sequences for overflow, simultaneous push/pop,
// saturation and reset. A queue-based reference tracks expected contents.
module tb_machine_d_capture;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int OVF_W = 8;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              F = 1'b0;
  logic [2:0]        S = '0;
  logic [11:0]       A = '0;
  logic              rd_en = 1'b0;
  logic [15:0]       rd_data;
  logic              empty;
  logic              full;
  logic [AW:0]       count;
  logic [15:0]       evt_cnt;
  logic              ovf;
  logic [OVF_W-1:0]  ovf_cnt;

  machine_d_capture #(.DEPTH(DEPTH), .AW(AW), .OVF_W(OVF_W)) dut (
    .CLK(CLK), .RESET(RESET), .F(F), .S(S), .A(A), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .evt_cnt(evt_cnt), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [15:0] mq[$];
  logic        m_fprev;
  logic [2:0]  m_sprev;
  int          m_evt;
  logic        m_ovf;
  int          m_ovfc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : 16'h0000;
    chk({tag, ".count"},   32'(count),   32'(mq.size()));
    chk({tag, ".empty"},   32'(empty),   32'(mq.size() == 0));
    chk({tag, ".full"},    32'(full),    32'(mq.size() == DEPTH));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_data));
    chk({tag, ".evt_cnt"}, 32'(evt_cnt), 32'(m_evt & 16'hFFFF));
    chk({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    chk({tag, ".ovf_cnt"}, 32'(ovf_cnt), 32'(m_ovfc));
  endtask

  task automatic do_reset(input logic f);
    RESET = 1'b1; F = f; rd_en = 1'b0;
    @(posedge CLK);
    mq.delete(); m_fprev = 1'b0; m_sprev = '0; m_evt = 0; m_ovf = 1'b0; m_ovfc = 0;
    #1;
    RESET = 1'b0;
    check_all("reset");
  endtask

  task automatic cyc(input logic f, input logic [2:0] s, input logic [11:0] a, input logic rd);
    logic pop_ok, fe, se, push;
    logic [15:0] ent;
    F = f; S = s; A = a; rd_en = rd;
    @(posedge CLK);
    pop_ok = rd && (mq.size() > 0);
    fe = f && !m_fprev;
`ifdef TRANSITION_LOG_EN
    se = (s != m_sprev) && !fe;
`else
    se = 1'b0;
`endif
    push = fe || se;
    ent = {se ? 1'b1 : 1'b0, s, a};
    if (pop_ok) void'(mq.pop_front());
    if (push) begin
      m_evt++;
      if (mq.size() < DEPTH) mq.push_back(ent);
      else begin
        m_ovf = 1'b1;
        if (m_ovfc < 255) m_ovfc++;
      end
    end
    m_fprev = f; m_sprev = s;
    #1;
    check_all("cyc");
  endtask

  typedef struct {
    logic        rst;
    logic        f;
    logic [2:0]  s;
    logic [11:0] a;
    logic        rd;
    int          exp_count;
    logic [15:0] exp_data;
    int          exp_evt;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mkv(logic rst, logic f, logic [2:0] s, logic [11:0] a, logic rd,
                               int ec, logic [15:0] ed, int ev);
    vec_t v;
    v.rst = rst; v.f = f; v.s = s; v.a = a; v.rd = rd;
    v.exp_count = ec; v.exp_data = ed; v.exp_evt = ev;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout count=%0d required=finish", count);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mkv(1, 0, 0, 12'h000, 0, 0, 16'h0000, 0);
    for (int i = 1; i <= 5; i++) vt[i] = mkv(0, 0, 0, 12'h000, 0, 0, 16'h0000, 0);
    vt[6]  = mkv(0, 1, 5, 12'hABC, 0, 1, 16'h5ABC, 1);
    vt[7]  = mkv(0, 0, 5, 12'hABC, 0, 1, 16'h5ABC, 1);
    vt[8]  = mkv(0, 0, 5, 12'hABC, 1, 0, 16'h0000, 1);
    vt[9]  = mkv(1, 0, 5, 12'hABC, 0, 0, 16'h0000, 0);
    for (int i = 10; i <= 13; i++) vt[i] = mkv(0, 1, 5, 12'hABC, 0, 1, 16'h5ABC, 1);
    vt[14] = mkv(0, 0, 5, 12'hABC, 1, 0, 16'h0000, 1);

    // Basic capture, pulse and held-high F
    for (int i = 0; i < 15; i++) begin
      S = vt[i].s; A = vt[i].a;
      if (vt[i].rst) do_reset(vt[i].f);
      else cyc(vt[i].f, vt[i].s, vt[i].a, vt[i].rd);
      chk("vec.count",   32'(count),   32'(vt[i].exp_count));
      chk("vec.rd_data", 32'(rd_data), 32'(vt[i].exp_data));
      chk("vec.evt_cnt", 32'(evt_cnt), 32'(vt[i].exp_evt));
    end

    // Ten pulses into an 8-deep FIFO, then drain in order
    S = 3'd5;
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 3'd5, 12'(i), 1'b0);
      cyc(1'b0, 3'd5, 12'(i), 1'b0);
    end
    chk("ovf10.full",    32'(full),    32'd1);
    chk("ovf10.count",   32'(count),   32'd8);
    chk("ovf10.ovf",     32'(ovf),     32'd1);
    chk("ovf10.ovf_cnt", 32'(ovf_cnt), 32'd2);
    chk("ovf10.evt_cnt", 32'(evt_cnt), 32'd10);
    for (int k = 1; k <= 8; k++) begin
      chk("drain.order", 32'(rd_data), 32'({4'h5, 12'(k)}));
      cyc(1'b0, 3'd5, 12'h0, 1'b1);
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // Full FIFO: push and pop on the same edge, no drop
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 3'd5, 12'h100 + 12'(i), 1'b0);
      cyc(1'b0, 3'd5, 12'h0, 1'b0);
    end
    cyc(1'b1, 3'd5, 12'h1FF, 1'b1);
    chk("fullpp.count",   32'(count),   32'd8);
    chk("fullpp.ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("fullpp.head",    32'(rd_data), 32'h5101);
    cyc(1'b0, 3'd5, 12'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 3'd5, 12'h0, 1'b1);
    // Empty FIFO: pop ignored, push lands
    cyc(1'b1, 3'd5, 12'h2AA, 1'b1);
    chk("emptypp.count", 32'(count),   32'd1);
    chk("emptypp.data",  32'(rd_data), 32'h52AA);
    cyc(1'b0, 3'd5, 12'h0, 1'b1);

    // Overflow counter saturation, then reset mid-traffic
    for (int i = 0; i < DEPTH + 260; i++) begin
      cyc(1'b1, 3'd5, 12'(i), 1'b0);
      cyc(1'b0, 3'd5, 12'(i), 1'b0);
    end
    chk("sat.ovf_cnt", 32'(ovf_cnt), 32'hFF);
    do_reset(1'b0);
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.ovf",   32'(ovf),   32'd0);
    chk("midrst.empty", 32'(empty), 32'd1);

    // F already high while in reset: first cycle after reset is an event
    do_reset(1'b1);
    cyc(1'b1, 3'd5, 12'h777, 1'b0);
    chk("postrst.count", 32'(count),   32'd1);
    chk("postrst.data",  32'(rd_data), 32'h5777);
    cyc(1'b0, 3'd5, 12'h0, 1'b1);

`ifdef TRANSITION_LOG_EN
    S = 3'd0;
    do_reset(1'b0);
    cyc(1'b0, 3'd2, 12'h123, 1'b0);
    chk("slog.data", 32'(rd_data), 32'hA123);
    cyc(1'b0, 3'd2, 12'h0, 1'b1);
    cyc(1'b1, 3'd4, 12'h456, 1'b0);
    chk("slog.prio.count", 32'(count),   32'd1);
    chk("slog.prio.data",  32'(rd_data), 32'h4456);
    chk("slog.prio.evt",   32'(evt_cnt), 32'd2);
    do_reset(1'b0);
    chk("slog.rst.count", 32'(count), 32'd0);
`else
    // S changes alone must not produce entries
    S = 3'd0;
    do_reset(1'b0);
    cyc(1'b0, 3'd2, 12'h123, 1'b0);
    cyc(1'b0, 3'd6, 12'h321, 1'b0);
    chk("nolog.count", 32'(count),   32'd0);
    chk("nolog.evt",   32'(evt_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
